// File: rtl/bus_ctrl_pkg.sv
// Shared types and elaboration helpers for the bus word sequencer.
package bus_ctrl_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // A bus must split into at least two whole sub-words.
    function automatic bit bus_params_ok(input int unsigned bus_size, input int unsigned word_size);
        return (word_size != 0) && (bus_size % word_size == 0) && (bus_size / word_size >= 2);
    endfunction

endpackage

// File: rtl/bus_word_sequencer_if.sv
// Frame-in / word-out handshake bundle for bus_word_sequencer.
interface bus_word_sequencer_if
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned WORD_SIZE = 4,
    localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE,
    localparam int unsigned IDX_W    = clog2(WORD_NUM)
);

    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_SIZE-1:0]  data_in;
    logic                 mode_reverse;
    logic                 skip_zero;
    logic                 word_valid;
    logic                 word_ready;
    logic [WORD_SIZE-1:0] word_out;
    logic [IDX_W-1:0]     word_idx;
    logic                 word_last;
    logic [WORD_NUM-1:0]  control_out;
    logic [BUS_SIZE-1:0]  data_out;
    logic                 frame_done;

    // Producer/consumer side.
    modport master (
        output in_valid, data_in, mode_reverse, skip_zero, word_ready,
        input  in_ready, word_valid, word_out, word_idx, word_last, control_out, data_out,
               frame_done
    );

    // Sequencer side.
    modport slave (
        input  in_valid, data_in, mode_reverse, skip_zero, word_ready,
        output in_ready, word_valid, word_out, word_idx, word_last, control_out, data_out,
               frame_done
    );

endinterface

// File: rtl/word_pick.sv
// Find the next set mask bit from a start index in either direction.
module word_pick
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned WORD_NUM = 4,
    localparam int unsigned IDX_W   = clog2(WORD_NUM)
) (
    input  logic [WORD_NUM-1:0] i_mask,
    input  logic [IDX_W-1:0]    i_start,
    input  logic                i_reverse,
    input  logic                i_inclusive,
    output logic [IDX_W-1:0]    o_next,
    output logic                o_found
);

    logic [WORD_NUM-1:0] w_elig;

    // Mark set positions lying strictly ahead of start (or at start when inclusive).
    always_comb begin
        w_elig = '0;
        for (int p = 0; p < WORD_NUM; p++) begin
            w_elig[p] = i_mask[p] &&
                        ((i_reverse ? (p < int'(i_start)) : (p > int'(i_start))) ||
                         (i_inclusive && (p == int'(i_start))));
        end
    end

    // Pick the eligible position closest to start; later loop hits overwrite earlier ones.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int p = WORD_NUM - 1; p >= 0; p--) begin
            if (!i_reverse && w_elig[p]) begin
                o_next  = IDX_W'(p);
                o_found = 1'b1;
            end
        end
        for (int p = 0; p < WORD_NUM; p++) begin
            if (i_reverse && w_elig[p]) begin
                o_next  = IDX_W'(p);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_word_sequencer.sv
// Latches a bus frame and streams its sub-words one per handshake.
module bus_word_sequencer
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned WORD_SIZE = 4,
    localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE,
    localparam int unsigned IDX_W    = clog2(WORD_NUM)
) (
    input logic                 clk,
    input logic                 rst_n,
    bus_word_sequencer_if.slave bus
);

    if (!bus_params_ok(BUS_SIZE, WORD_SIZE)) begin : g_param_check
        $error("bus_word_sequencer: BUS_SIZE must be a multiple of WORD_SIZE, >= 2 words");
    end

    state_e               r_state, w_state_next;
    logic [BUS_SIZE-1:0]  r_data, r_dout, w_dout_next;
    logic [WORD_NUM-1:0]  r_ctrl, r_mask, w_in_ctrl, w_in_mask;
    logic                 r_rev;
    logic [IDX_W-1:0]     r_idx, w_first_start, w_first_idx, w_adv_idx;
    logic                 w_first_found, w_adv_found, w_accept, w_advance, w_send;
    logic [WORD_SIZE-1:0] w_word;

    // Decode the incoming frame: non-zero mask, word-reversed bus and first search start.
    always_comb begin
        w_in_ctrl   = '0;
        w_dout_next = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            w_in_ctrl[i] = |bus.data_in[i*WORD_SIZE +: WORD_SIZE];
            w_dout_next[(WORD_NUM-1-i)*WORD_SIZE +: WORD_SIZE] =
                bus.data_in[i*WORD_SIZE +: WORD_SIZE];
        end
        // Without skipping every index is eligible, so the same search yields +/-1 stepping.
        w_in_mask     = bus.skip_zero ? w_in_ctrl : '1;
        w_first_start = bus.mode_reverse ? IDX_W'(WORD_NUM - 1) : '0;
    end

    word_pick #(
        .WORD_NUM (WORD_NUM)
    ) u_pick_first (
        .i_mask      (w_in_mask),
        .i_start     (w_first_start),
        .i_reverse   (bus.mode_reverse),
        .i_inclusive (1'b1),
        .o_next      (w_first_idx),
        .o_found     (w_first_found)
    );

    // Queried from registered state only, so word_last needs no input path.
    word_pick #(
        .WORD_NUM (WORD_NUM)
    ) u_pick_adv (
        .i_mask      (r_mask),
        .i_start     (r_idx),
        .i_reverse   (r_rev),
        .i_inclusive (1'b0),
        .o_next      (w_adv_idx),
        .o_found     (w_adv_found)
    );

    // Select the latched sub-word at the current index.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_word = r_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign w_send    = (r_state == StSend);
    assign w_accept  = (r_state == StIdle) && bus.in_valid;
    assign w_advance = w_send && bus.word_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.in_valid) w_state_next = w_first_found ? StSend : StDone;
            StSend:  if (bus.word_ready && !w_adv_found) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Frame latch and emit-index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_dout <= '0;
            r_ctrl <= '0;
            r_mask <= '0;
            r_rev  <= 1'b0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_data <= bus.data_in;
            r_dout <= w_dout_next;
            r_ctrl <= w_in_ctrl;
            r_mask <= w_in_mask;
            r_rev  <= bus.mode_reverse;
            r_idx  <= w_first_idx;
        end else if (w_advance && w_adv_found) begin
            r_idx <= w_adv_idx;
        end
    end

    // Output decode from registered state.
    always_comb begin
        bus.in_ready    = (r_state == StIdle);
        bus.word_valid  = w_send;
        bus.word_out    = w_send ? w_word : '0;
        bus.word_idx    = w_send ? r_idx : '0;
        bus.word_last   = w_send && !w_adv_found;
        bus.control_out = r_ctrl;
        bus.data_out    = r_dout;
        bus.frame_done  = (r_state == StDone);
    end

endmodule

// File: doc/bus_word_sequencer.md
# bus_word_sequencer

Parametrised successor to the combinational bus splitter. Accepts a full bus word with a valid/ready handshake, latches it, and streams its WORD_SIZE sub-words one per handshake, in forward or reverse order, optionally skipping all-zero sub-words. It also holds the per-word non-zero mask and the word-reversed bus for the frame. It sits between a bus producer and a word-wide consumer in the control path.

## Interface
- BUS_SIZE, 16, bus width in bits; must be an integer multiple of WORD_SIZE.
- WORD_SIZE, 4, sub-word width in bits.
- WORD_NUM, BUS_SIZE/WORD_SIZE, derived and never overridden; must be ≥ 2.
- IDX_W, clog2(WORD_NUM), derived index width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in, mode_reverse and skip_zero are valid.
- in_ready  out  1  block is in IDLE and accepts a frame.
- data_in  in  BUS_SIZE  frame; sub-word i is data_in[i*WORD_SIZE +: WORD_SIZE].
- mode_reverse  in  1  0 = emit index ascending; 1 = emit index descending. Sampled at accept.
- skip_zero  in  1  1 = do not emit sub-words equal to zero. Sampled at accept.
- word_valid  out  1  word_out, word_idx and word_last are valid.
- word_ready  in  1  consumer takes the word.
- word_out  out  WORD_SIZE  current sub-word.
- word_idx  out  IDX_W  position i of the current sub-word.
- word_last  out  1  current word is the final emitted word of the frame.
- control_out  out  WORD_NUM  bit i = OR-reduction of sub-word i of the latched frame.
- data_out  out  BUS_SIZE  latched frame with word order reversed: out word j = in word WORD_NUM-1-j.
- frame_done  out  1  one-cycle pulse marking the end of the frame.

## Operation
- **FSM states:** IDLE, SEND, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch data_in, mode and skip, and load control_out and data_out.
  - Compute the first emit index:
    - skip_zero = 0: index 0 (forward) or WORD_NUM-1 (reverse).
    - skip_zero = 1: the first set mask bit in emit order.
  - If skip_zero = 1 and the mask is all zero, go to DONE. Otherwise go to SEND.
- **SEND:**
  - word_valid = 1.
  - word_out = latched sub-word[word_idx].
  - word_last = 1 when no further eligible index exists in emit order.
  - On word_valid & word_ready:
    - not last: advance to the next eligible index (next set mask bit when skipping, otherwise ±1);
    - last: go to DONE.
  - While word_ready = 0, word_out, word_idx and word_last are held stable. No word is duplicated or dropped.
- **DONE:**
  - frame_done = 1 and in_ready = 0 for exactly one cycle, then go to IDLE.
- in_valid is ignored outside IDLE.
- control_out and data_out hold their value until the next accept.
- **Reset (asynchronous, mid-frame or otherwise):**
  - state = IDLE and all registers cleared.
  - No frame_done for an aborted frame.

## Timing
- **Values while reset is low:**
  - in_ready = 1 (IDLE decode).
  - word_valid, word_out, word_idx, word_last, control_out, data_out and frame_done are all 0.
- **Latency:**
  - Accept at edge t: word_valid high in cycle t+1.
  - Empty skipped frame: frame_done high in cycle t+1.
- Last word handshake at edge k: frame_done high in cycle k+1, in_ready high in cycle k+2.
- Throughput with word_ready held high: one word per cycle, giving N emitted words + 2 cycles per frame.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or word_ready to any output.

## Structure
- **Package bus_ctrl_pkg:**
  - state encoding constants (IDLE, SEND, DONE);
  - clog2 function;
  - parameter-legality checks (BUS_SIZE % WORD_SIZE == 0, WORD_NUM ≥ 2).
- **Sub-module word_pick:**
  - Combinational find-next-set over the WORD_NUM mask.
  - Inputs: start index, direction, inclusive flag.
  - Outputs: next index, found flag.
  - Used for both the first index and the advance; word_last = !found on the advance query.

## Test plan
- **Forward, no skip:** BUS=16, WORD=4, data_in=16'hA0B3, mode_reverse=0, skip_zero=0, word_ready=1.
  - Words 3, B, 0, A with idx 0, 1, 2, 3; word_last on idx 3.
  - control_out=4'b1011, data_out=16'h3B0A.
  - frame_done in the cycle after the last handshake.
- **Reverse with skip:** same data, mode_reverse=1, skip_zero=1.
  - Words A, B, 3 with idx 3, 1, 0; word_last on idx 0.
  - Idx 2 is never emitted.
- **All-zero with skip:** data_in=0, skip_zero=1.
  - word_valid never rises; frame_done at t+1; control_out=0; in_ready back at t+2.
- **Backpressure:** forward 16'hA0B3 with word_ready low for 3 cycles while idx 1 is presented.
  - word_out=B and idx=1 held stable.
  - Exactly 4 words total, no duplicates.
- **Reset mid-frame:** reset low after 2 handshakes.
  - Outputs immediately zero, in_ready=1, no frame_done.
  - The next frame starts at idx 0.
- **Back-to-back frames:** in_valid held high through SEND and DONE.
  - Ignored until IDLE; the second frame is accepted exactly 1 cycle after the frame_done pulse.
